ctrl_seq: RTL

//  Multi-cycle fetch/decode/execute sequencer that drives the alu control and flag inputs.

---
 rtl/ctrl_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ctrl_seq.sv
// Fetch/decode/execute sequencer for the project1 processor: owns the PC, IR and
// carry/borrow flags, and drives ALU decode strobes, register-file and data-memory strobes.
module ctrl_seq #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk_pi,
  input  logic        reset_n_pi,
  input  logic        imem_rdy_pi,
  input  logic [15:0] imem_data_pi,
  output logic        imem_req_po,
  output logic [15:0] pc_po,
  output logic [2:0]  reg1_addr_po,
  output logic [2:0]  reg2_addr_po,
  input  logic [15:0] reg1_data_pi,
  input  logic [15:0] reg2_data_pi,
  output logic        arith_1op_po,
  output logic        arith_2op_po,
  output logic        addi_po,
  output logic        subi_po,
  output logic        load_or_store_po,
  output logic        stc_cmd_po,
  output logic        stb_cmd_po,
  output logic [2:0]  alu_func_po,
  output logic [5:0]  immediate_po,
  output logic        carry_flag_po,
  output logic        borrow_flag_po,
  input  logic        alu_carry_pi,
  input  logic        alu_borrow_pi,
  output logic        reg_we_po,
  output logic [2:0]  reg_waddr_po,
  output logic        dmem_req_po,
  output logic        dmem_we_po,
  input  logic        dmem_rdy_pi,
  output logic        halted_po
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALTED} state_t;

  // Opcodes 4'hD and 4'hE are unassigned and fall through to the NOP default.
  typedef enum logic [3:0] {
    OP_NOP   = 4'h0, OP_ARITH_2OP = 4'h1, OP_ARITH_1OP = 4'h2, OP_MOVI = 4'h3,
    OP_ADDI  = 4'h4, OP_SUBI      = 4'h5, OP_LOAD      = 4'h6, OP_STOR = 4'h7,
    OP_BEQ   = 4'h8, OP_BGE       = 4'h9, OP_BLE       = 4'hA, OP_BC   = 4'hB,
    OP_J     = 4'hC, OP_CTRL      = 4'hF
  } opcode_t;

  localparam logic [11:0] CTRL_STC   = 12'h001;
  localparam logic [11:0] CTRL_STB   = 12'h002;
  localparam logic [11:0] CTRL_RESET = 12'hAAA;
  localparam logic [11:0] CTRL_HALT  = 12'hFFF;

  state_t      r_state, w_next_state;
  logic [15:0] r_pc, w_next_pc;
  logic [15:0] r_ir;
  logic        r_carry, w_next_carry;
  logic        r_borrow, w_next_borrow;
  logic        r_active;

  opcode_t     w_op;
  logic [11:0] w_ctrl;
  logic        w_ir_load;
  logic        w_decode_valid;
  logic        w_branch_taken;
  logic [15:0] w_pc_inc;
  logic [15:0] w_offset;
  logic        w_imem_req, w_dmem_req, w_reg_we;

  assign w_op           = opcode_t'(r_ir[15:12]);
  assign w_ctrl         = r_ir[11:0];
  assign w_pc_inc       = r_pc + 16'd1;
  assign w_offset       = {{10{r_ir[5]}}, r_ir[5:0]};
  // r_active keeps imem_req_po low while reset is held and rises on the first edge after release.
  assign w_ir_load      = (r_state == S_FETCH) && r_active && imem_rdy_pi;
  assign w_decode_valid = (r_state == S_DECODE) || (r_state == S_EXEC) || (r_state == S_MEM);

  always_comb begin
    w_branch_taken = 1'b0;
    case (w_op)
      OP_BEQ:  w_branch_taken = (reg1_data_pi == reg2_data_pi);
      OP_BGE:  w_branch_taken = (reg1_data_pi >= reg2_data_pi);
      OP_BLE:  w_branch_taken = (reg1_data_pi <= reg2_data_pi);
      OP_BC:   w_branch_taken = r_carry;
      default: w_branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    w_next_state  = r_state;
    w_next_pc     = r_pc;
    w_next_carry  = r_carry;
    w_next_borrow = r_borrow;
    w_imem_req    = 1'b0;
    w_dmem_req    = 1'b0;
    w_reg_we      = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_imem_req = r_active;
        if (w_ir_load) w_next_state = S_DECODE;
      end
      S_DECODE: w_next_state = S_EXEC;
      S_EXEC: begin
        w_next_carry  = alu_carry_pi;
        w_next_borrow = alu_borrow_pi;
        w_next_pc     = w_pc_inc;
        w_next_state  = S_FETCH;
        case (w_op)
          OP_ARITH_1OP, OP_ARITH_2OP, OP_MOVI, OP_ADDI, OP_SUBI: w_reg_we = 1'b1;
          OP_LOAD, OP_STOR: begin
            // The PC advances when the data access completes, not here.
            w_next_pc    = r_pc;
            w_next_state = S_MEM;
          end
          OP_BEQ, OP_BGE, OP_BLE, OP_BC:
            if (w_branch_taken) w_next_pc = w_pc_inc + w_offset;
          OP_J: w_next_pc = {r_pc[15:12], r_ir[11:0]};
          OP_CTRL: begin
            if (w_ctrl == CTRL_RESET) begin
              w_next_pc     = RESET_PC;
              w_next_carry  = 1'b0;
              w_next_borrow = 1'b0;
            end else if (w_ctrl == CTRL_HALT) begin
              w_next_state = S_HALTED;
            end
          end
          default: ;
        endcase
      end
      S_MEM: begin
        w_dmem_req = 1'b1;
        if (dmem_rdy_pi) begin
          w_reg_we     = (w_op == OP_LOAD);
          w_next_pc    = w_pc_inc;
          w_next_state = S_FETCH;
        end
      end
      S_HALTED: ;
      default: w_next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_pi or negedge reset_n_pi) begin
    if (!reset_n_pi) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_ir     <= 16'h0000;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      r_active <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state  <= w_next_state;
      r_pc     <= w_next_pc;
      r_carry  <= w_next_carry;
      r_borrow <= w_next_borrow;
      r_active <= 1'b1;
      if (w_ir_load) r_ir <= imem_data_pi;
    end
  end

  assign imem_req_po      = w_imem_req;
  assign pc_po            = r_pc;
  assign reg1_addr_po     = r_ir[8:6];
  assign reg2_addr_po     = (w_op == OP_STOR) ? r_ir[11:9] : r_ir[5:3];
  assign arith_1op_po     = w_decode_valid && (w_op == OP_ARITH_1OP);
  assign arith_2op_po     = w_decode_valid && (w_op == OP_ARITH_2OP);
  assign addi_po          = w_decode_valid && (w_op == OP_ADDI);
  assign subi_po          = w_decode_valid && (w_op == OP_SUBI);
  assign load_or_store_po = w_decode_valid && ((w_op == OP_LOAD) || (w_op == OP_STOR));
  assign stc_cmd_po       = w_decode_valid && (w_op == OP_CTRL) && (w_ctrl == CTRL_STC);
  assign stb_cmd_po       = w_decode_valid && (w_op == OP_CTRL) && (w_ctrl == CTRL_STB);
  assign alu_func_po      = r_ir[2:0];
  assign immediate_po     = r_ir[5:0];
  assign carry_flag_po    = r_carry;
  assign borrow_flag_po   = r_borrow;
  assign reg_we_po        = w_reg_we;
  assign reg_waddr_po     = r_ir[11:9];
  assign dmem_req_po      = w_dmem_req;
  assign dmem_we_po       = w_dmem_req && (w_op == OP_STOR);
  assign halted_po        = (r_state == S_HALTED);

endmodule
